// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle operand/opcode holder in front of the 32-bit ALU.
// Screens illegal opcodes and divide-by-zero, captures the 64-bit result into Z.
module alu_sequencer #(
   parameter int unsigned SIMPLE_CYCLES = 1,
   parameter int unsigned MULDIV_CYCLES = 4
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        req_valid,
   input  logic [4:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        req_ready,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [4:0]  alu_op,
   input  logic [63:0] alu_c,
   output logic [31:0] z_hi,
   output logic [31:0] z_lo,
   output logic        done,
   output logic        err,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      DONE
   } state_t;

   localparam logic [3:0] SIMPLE_LOAD = 4'(SIMPLE_CYCLES - 1);
   localparam logic [3:0] MULDIV_LOAD = 4'(MULDIV_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        first_q, first_d;
   logic        reject_q, reject_d;
   logic [31:0] a_d, b_d;
   logic [4:0]  op_d;
   logic [31:0] zh_d, zl_d;
   logic        done_d, err_d;
   logic        bad_op;
   logic        rej_now;
   logic        is_muldiv;

   assign req_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);

   assign is_muldiv = (req_op == 5'd10) || (req_op == 5'd11);

   // Operands are held through EXEC, so the screen is a function of them;
   // it only needs latching once, on the first EXEC cycle.
   assign bad_op  = (alu_op >= 5'd14) ||
                    ((alu_op == 5'd11) && (alu_b == 32'd0));
   assign rej_now = reject_q || (first_q && bad_op);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      first_d  = first_q;
      reject_d = reject_q;
      a_d      = alu_a;
      b_d      = alu_b;
      op_d     = alu_op;
      zh_d     = z_hi;
      zl_d     = z_lo;
      done_d   = 1'b0;
      err_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               a_d      = req_a;
               b_d      = req_b;
               op_d     = req_op;
               cnt_d    = is_muldiv ? MULDIV_LOAD : SIMPLE_LOAD;
               first_d  = 1'b1;
               reject_d = 1'b0;
               state_d  = EXEC;
            end
         end
         EXEC: begin
            first_d  = 1'b0;
            reject_d = rej_now;
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (!rej_now) begin
                  zh_d = alu_c[63:32];
                  zl_d = alu_c[31:0];
               end
               done_d  = 1'b1;
               err_d   = rej_now;
               state_d = DONE;
            end
         end
         DONE: begin
            reject_d = 1'b0;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         first_q  <= 1'b0;
         reject_q <= 1'b0;
         alu_a    <= 32'd0;
         alu_b    <= 32'd0;
         alu_op   <= 5'd0;
         z_hi     <= 32'd0;
         z_lo     <= 32'd0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         first_q  <= first_d;
         reject_q <= reject_d;
         alu_a    <= a_d;
         alu_b    <= b_d;
         alu_op   <= op_d;
         z_hi     <= zh_d;
         z_lo     <= zl_d;
         done     <= done_d;
         err      <= err_d;
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized transaction-level check of alu_sequencer
// against a reference model of the ALU and the request/latency rules.
module tb_alu_sequencer;

   localparam int SC = 1;
   localparam int MC = 4;

   logic        clock = 1'b0;
   logic        clear = 1'b1;
   logic        req_valid = 1'b0;
   logic [4:0]  req_op = '0;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic        req_ready;
   logic [31:0] alu_a, alu_b;
   logic [4:0]  alu_op;
   logic [63:0] alu_c;
   logic [31:0] z_hi, z_lo;
   logic        done, err, busy;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [63:0] z_model = '0;

   logic [4:0]  s_op[$];
   logic [31:0] s_a[$];
   logic [31:0] s_b[$];

   alu_sequencer #(
      .SIMPLE_CYCLES(SC),
      .MULDIV_CYCLES(MC)
   ) dut (
      .clock(clock),
      .clear(clear),
      .req_valid(req_valid),
      .req_op(req_op),
      .req_a(req_a),
      .req_b(req_b),
      .req_ready(req_ready),
      .alu_a(alu_a),
      .alu_b(alu_b),
      .alu_op(alu_op),
      .alu_c(alu_c),
      .z_hi(z_hi),
      .z_lo(z_lo),
      .done(done),
      .err(err),
      .busy(busy)
   );

   always #5 clock = ~clock;

   function automatic logic [63:0] sx(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   function automatic logic [63:0] alu_fn(input logic [4:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
      logic signed [63:0] sa, sb, q, r;
      logic [4:0] s;
      sa = signed'(sx(a));
      sb = signed'(sx(b));
      s  = b[4:0];
      case (op)
         5'd0:  return sx(a | b);
         5'd1:  return sx(a & b);
         5'd2:  return sa + sb;
         5'd3:  return sa - sb;
         5'd4:  return -sa;
         5'd5:  return sx(a >> s);
         5'd6:  return sx(a << s);
         5'd7:  return sx((a >> s) | (a << (6'd32 - {1'b0, s})));
         5'd8:  return sx((a << s) | (a >> (6'd32 - {1'b0, s})));
         5'd9:  return sx($signed(a) >>> s);
         5'd10: return sa * sb;
         5'd11: begin
            if (b == 32'd0) return 64'd0;
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         5'd12: return sa + 64'sd1;
         5'd13: return sx(~a);
         default: return 64'd0;
      endcase
   endfunction

   assign alu_c = alu_fn(alu_op, alu_a, alu_b);

   function automatic int lat(input logic [4:0] op);
      return (op == 5'd10 || op == 5'd11) ? MC : SC;
   endfunction

   function automatic bit is_bad(input logic [4:0] op, input logic [31:0] b);
      return (op >= 5'd14) || (op == 5'd11 && b == 32'd0);
   endfunction

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic scramble();
      req_op = 5'($urandom);
      req_a  = $urandom;
      req_b  = $urandom;
   endtask

   task automatic run_op(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b);
      logic [63:0] exp_z;
      bit          e;
      int          w, cyc;
      e     = is_bad(op, b);
      exp_z = e ? z_model : alu_fn(op, a, b);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      w = 0;
      @(negedge clock);
      while (!req_ready && w < 50) begin
         @(negedge clock);
         w++;
      end
      if (!req_ready) begin
         chk("accept_timeout", 64'(req_ready), 64'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      scramble();
      cyc = 0;
      while (!done && cyc < 40) begin
         chk("hold_a", 64'(alu_a), 64'(a));
         chk("hold_b", 64'(alu_b), 64'(b));
         chk("hold_op", 64'(alu_op), 64'(op));
         chk("z_early", {z_hi, z_lo}, z_model);
         chk("busy", 64'(busy), 64'd1);
         @(posedge clock);
         #1;
         cyc++;
      end
      chk("latency", 64'(cyc), 64'(lat(op)));
      chk("err", 64'(err), 64'(e));
      chk("z", {z_hi, z_lo}, exp_z);
      z_model = exp_z;
      @(posedge clock);
      #1;
      chk("done_pulse", 64'(done), 64'd0);
      chk("err_idle", 64'(err), 64'd0);
      chk("ready_back", 64'(req_ready), 64'd1);
   endtask

   task automatic stream();
      int   n, idx, dn, t, last;
      bit   acc;
      logic [63:0] exp_z;
      n    = s_op.size();
      idx  = 0;
      dn   = 0;
      t    = 0;
      last = 0;
      req_valid = 1'b1;
      req_op = s_op[0];
      req_a  = s_a[0];
      req_b  = s_b[0];
      while (dn < n && t < 100) begin
         @(negedge clock);
         acc = req_ready && req_valid && (idx < n);
         @(posedge clock);
         #1;
         t++;
         if (done) begin
            exp_z = is_bad(s_op[dn], s_b[dn]) ? z_model
                                              : alu_fn(s_op[dn], s_a[dn], s_b[dn]);
            chk("stream_z", {z_hi, z_lo}, exp_z);
            chk("stream_err", 64'(err), 64'(is_bad(s_op[dn], s_b[dn])));
            z_model = exp_z;
            dn++;
         end
         if (acc) begin
            if (idx > 0)
               chk("spacing", 64'(t - last), 64'(lat(s_op[idx-1]) + 2));
            last = t;
            idx++;
            if (idx < n) begin
               req_op = s_op[idx];
               req_a  = s_a[idx];
               req_b  = s_b[idx];
            end else begin
               req_valid = 1'b0;
               scramble();
            end
         end
      end
      chk("stream_accepts", 64'(idx), 64'(n));
      chk("stream_dones", 64'(dn), 64'(n));
      req_valid = 1'b0;
      @(posedge clock);
      #1;
      s_op.delete();
      s_a.delete();
      s_b.delete();
   endtask

   initial begin
      logic [4:0]  op;
      logic [31:0] a, b;

      // clear for two edges, with a request that must be dropped
      clear     = 1'b1;
      req_valid = 1'b1;
      req_op    = 5'd2;
      req_a     = 32'd1;
      req_b     = 32'd1;
      @(posedge clock);
      @(posedge clock);
      #1;
      clear     = 1'b0;
      req_valid = 1'b0;
      chk("rst_z", {z_hi, z_lo}, 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_alu", {27'd0, alu_op, alu_a}, 64'd0);

      run_op(5'd2, 32'd5, 32'd7);
      chk("add_lo", 64'(z_lo), 64'd12);
      chk("add_hi", 64'(z_hi), 64'd0);
      run_op(5'd3, 32'd3, 32'd5);
      chk("sub_lo", 64'(z_lo), 64'hFFFF_FFFE);
      chk("sub_hi", 64'(z_hi), 64'hFFFF_FFFF);

      run_op(5'd2, 32'd5, 32'd7);
      run_op(5'd11, 32'd9, 32'd0);
      chk("div0_keep", {z_hi, z_lo}, 64'd12);
      run_op(5'd20, 32'd1, 32'd2);
      chk("ill_keep", {z_hi, z_lo}, 64'd12);

      run_op(5'd10, 32'h10000, 32'h10000);
      chk("mul_hi", 64'(z_hi), 64'd1);
      chk("mul_lo", 64'(z_lo), 64'd0);

      // second request waits behind a multiply
      s_op.push_back(5'd10); s_a.push_back(32'd7); s_b.push_back(32'hFFFF_FFFD);
      s_op.push_back(5'd2);  s_a.push_back(32'd1); s_b.push_back(32'd2);
      stream();

      // clear during EXEC abandons the multiply
      req_valid = 1'b1;
      req_op    = 5'd10;
      req_a     = 32'd3;
      req_b     = 32'd4;
      @(negedge clock);
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      @(posedge clock);
      #1;
      clear = 1'b1;
      @(posedge clock);
      #1;
      clear = 1'b0;
      z_model = '0;
      chk("mid_done", 64'(done), 64'd0);
      chk("mid_z", {z_hi, z_lo}, 64'd0);
      chk("mid_ready", 64'(req_ready), 64'd1);
      chk("mid_busy", 64'(busy), 64'd0);
      repeat (4) begin
         @(posedge clock);
         #1;
         chk("mid_nodone", 64'(done), 64'd0);
      end
      run_op(5'd2, 32'd40, 32'd2);

      // streaming simple ops
      for (int i = 0; i < 3; i++) begin
         s_op.push_back(5'($urandom_range(0, 9)));
         s_a.push_back($urandom);
         s_b.push_back($urandom);
      end
      stream();

      // random mix including illegal opcodes and divide by zero
      for (int i = 0; i < 40; i++) begin
         op = 5'($urandom_range(0, 17));
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         run_op(op, a, b);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
